dif_radix2_64p_frame_sink: RTL and testbench

Receive-side terminator for the 64-point FFT output stream. It accepts the naturally-ordered, non-backpressurable dout_re/dout_im/dout_valid stream from the FFT top and collects each 64-sample frame into a two-bank ping-pong buffer. It re-emits each frame on a valid/ready stream with bin index and last flag. If the downstream cannot keep up, it drops whole frames and flags the overflow, instead of stalling the FFT.

---
 rtl/dif_radix2_64p_frame_sink.sv | 159 +++++++++++++++
 tb/tb_dif_radix2_64p_frame_sink.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dif_radix2_64p_frame_sink.sv
// Ping-pong frame sink for the 64-point FFT output stream: buffers whole frames and
// re-emits them on a valid/ready stream, dropping complete frames when both banks are busy.
module dif_radix2_64p_frame_sink #(
   parameter int unsigned DATA_WIDTH = 17,
   parameter int unsigned FFT_NUM    = 6,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fft_re,
   input  logic [DATA_WIDTH-1:0] fft_im,
   input  logic                  fft_valid,
   output logic [DATA_WIDTH-1:0] m_re,
   output logic [DATA_WIDTH-1:0] m_im,
   output logic [FFT_NUM-1:0]    m_idx,
   output logic                  m_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   localparam int unsigned N = 1 << FFT_NUM;

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_e;

   logic [2*DATA_WIDTH-1:0] mem_q [2*N];

   wr_state_e               wr_state_q, wr_state_d;
   logic                    wbank_q, wbank_d;
   logic [FFT_NUM-1:0]      wptr_q, wptr_d;
   logic [1:0]              full_q, full_d;
   logic                    rbank_q, out_bank_q;
   logic [FFT_NUM-1:0]      rptr_q;
   logic [DATA_WIDTH-1:0]   m_re_q, m_im_q;
   logic [FFT_NUM-1:0]      m_idx_q;
   logic                    m_last_q, m_valid_q;
   logic [CNT_WIDTH-1:0]    frame_cnt_q, drop_cnt_q;
   logic                    overflow_q;

   logic                    hs, free_ev, claim_ok, wr_en, fill_done, drop_ev, ld_en;
   logic [FFT_NUM-1:0]      wr_addr;

   always_comb begin
      hs       = m_valid_q && m_ready;
      free_ev  = hs && m_last_q;
      // A bank released by the reader this cycle may be claimed by a new frame at once.
      claim_ok = !full_q[wbank_q] || (free_ev && (out_bank_q == wbank_q));

      wr_en      = 1'b0;
      wr_addr    = wptr_q;
      fill_done  = 1'b0;
      drop_ev    = 1'b0;
      wr_state_d = wr_state_q;
      wptr_d     = wptr_q;
      wbank_d    = wbank_q;

      case (wr_state_q)
         W_IDLE: begin
            if (fft_valid) begin
               wptr_d = FFT_NUM'(1);
               if (claim_ok) begin
                  wr_en      = 1'b1;
                  wr_addr    = '0;
                  wr_state_d = W_FILL;
               end else begin
                  drop_ev    = 1'b1;
                  wr_state_d = W_DROP;
               end
            end
         end
         W_FILL: begin
            if (fft_valid) begin
               wr_en  = 1'b1;
               wptr_d = wptr_q + FFT_NUM'(1);
               if (wptr_q == '1) begin
                  fill_done  = 1'b1;
                  wr_state_d = W_IDLE;
                  wbank_d    = ~wbank_q;
               end
            end
         end
         W_DROP: begin
            if (fft_valid) begin
               wptr_d = wptr_q + FFT_NUM'(1);
               if (wptr_q == '1) wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase

      full_d = full_q;
      if (free_ev)   full_d[out_bank_q] = 1'b0;
      if (fill_done) full_d[wbank_q]    = 1'b1;

      // The load side runs ahead of the presented beat, so it may already point at
      // the next bank while the last beat of the current one still awaits m_ready.
      ld_en = full_q[rbank_q] && (!m_valid_q || m_ready);
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[{wbank_q, wr_addr}] <= {fft_re, fft_im};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q  <= W_IDLE;
         wbank_q     <= 1'b0;
         wptr_q      <= '0;
         full_q      <= '0;
         rbank_q     <= 1'b0;
         out_bank_q  <= 1'b0;
         rptr_q      <= '0;
         m_re_q      <= '0;
         m_im_q      <= '0;
         m_idx_q     <= '0;
         m_last_q    <= 1'b0;
         m_valid_q   <= 1'b0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         wbank_q    <= wbank_d;
         wptr_q     <= wptr_d;
         full_q     <= full_d;

         if (ld_en) begin
            {m_re_q, m_im_q} <= mem_q[{rbank_q, rptr_q}];
            m_idx_q    <= rptr_q;
            m_last_q   <= (rptr_q == '1);
            m_valid_q  <= 1'b1;
            out_bank_q <= rbank_q;
            rptr_q     <= rptr_q + FFT_NUM'(1);
            if (rptr_q == '1) rbank_q <= ~rbank_q;
         end else if (hs) begin
            m_valid_q <= 1'b0;
         end

         if (free_ev) frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
         if (drop_ev) drop_cnt_q  <= drop_cnt_q + CNT_WIDTH'(1);

         if (drop_ev)      overflow_q <= 1'b1;
         else if (ovf_clr) overflow_q <= 1'b0;
      end
   end

   assign m_re      = m_re_q;
   assign m_im      = m_im_q;
   assign m_idx     = m_idx_q;
   assign m_last    = m_last_q;
   assign m_valid   = m_valid_q;
   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_dif_radix2_64p_frame_sink.sv
// Randomized bench for dif_radix2_64p_frame_sink against a frame-level occupancy/scoreboard model.
module tb_dif_radix2_64p_frame_sink;

   localparam int unsigned DW = 17;
   localparam int unsigned FN = 6;
   localparam int unsigned CW = 16;
   localparam int          NF = 64;

   logic          clk = 1'b0;
   logic          rst, fft_valid, m_ready, ovf_clr;
   logic [DW-1:0] fft_re, fft_im, m_re, m_im;
   logic [FN-1:0] m_idx;
   logic          m_last, m_valid, overflow;
   logic [CW-1:0] frame_cnt, drop_cnt;

   dif_radix2_64p_frame_sink #(.DATA_WIDTH(DW), .FFT_NUM(FN), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .fft_re(fft_re), .fft_im(fft_im), .fft_valid(fft_valid),
      .m_re(m_re), .m_im(m_im), .m_idx(m_idx), .m_last(m_last), .m_valid(m_valid),
      .m_ready(m_ready), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
      .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: frames are accepted iff fewer than two undelivered frames are held
   // when their bin 0 arrives (a frame whose last beat is accepted that cycle counts as gone).
   bit                     mon_en = 1'b0;
   int                     cyc = 0;
   logic [2*DW+FN-1:0]     exp_q[$];
   int                     exp_t[$];
   logic [2*DW-1:0]        frame_buf[$];
   int                     last_pop, s_cnt, completed, delivered, deadline;
   bit                     cur_drop, drop_now;
   logic [CW-1:0]          m_frames, m_drops;
   logic                   m_ovf;
   logic [2*DW+FN:0]       exp_beat;

   task automatic model_reset();
      exp_q.delete(); exp_t.delete(); frame_buf.delete();
      last_pop = -10; s_cnt = 0; completed = 0; delivered = 0; cur_drop = 1'b0;
      m_frames = '0; m_drops = '0; m_ovf = 1'b0;
   endtask

   initial model_reset();

   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
         chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         if (exp_q.size() == 0) begin
            if (m_valid) chk("spurious_valid", 64'(m_valid), 64'd0);
         end else begin
            exp_beat = {exp_q[0], (exp_q[0][FN-1:0] == FN'(NF-1))};
            deadline = (last_pop + 1 > exp_t[0] + 2) ? last_pop + 1 : exp_t[0] + 2;
            if (m_valid)
               chk("beat", 64'({m_re, m_im, m_idx, m_last}), 64'(exp_beat));
            else if (cyc >= deadline)
               chk("valid_deadline", 64'(m_valid), 64'd1);
         end
      end
      if (rst) begin
         model_reset();
      end else begin
         drop_now = 1'b0;
         if (m_valid && m_ready && exp_q.size() > 0) begin
            if (exp_q[0][FN-1:0] == FN'(NF-1)) begin
               delivered++;
               m_frames++;
            end
            void'(exp_q.pop_front());
            void'(exp_t.pop_front());
            last_pop = cyc;
         end
         if (fft_valid) begin
            if (s_cnt == 0) begin
               cur_drop = (completed - delivered) >= 2;
               if (cur_drop) begin
                  m_drops++;
                  m_ovf    = 1'b1;
                  drop_now = 1'b1;
               end
               frame_buf.delete();
            end
            if (!cur_drop) frame_buf.push_back({fft_re, fft_im});
            s_cnt++;
            if (s_cnt == NF) begin
               s_cnt = 0;
               if (!cur_drop) begin
                  completed++;
                  for (int k = 0; k < NF; k++) begin
                     exp_q.push_back({frame_buf[k], FN'(k)});
                     exp_t.push_back(cyc);
                  end
               end
            end
         end
         if (ovf_clr && !drop_now) m_ovf = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; fft_valid = 1'b0; ovf_clr = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic send_frame(input bit ramp, input int gap_max);
      for (int i = 0; i < NF; i++) begin
         if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
            fft_valid = 1'b0;
            repeat ($urandom_range(1, gap_max)) step();
         end
         fft_valid = 1'b1;
         fft_re    = ramp ? DW'(i) : DW'($urandom);
         fft_im    = ramp ? DW'(0) - DW'(i) : DW'($urandom);
         step();
      end
      fft_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      m_ready = 1'b1;
      while ((exp_q.size() != 0 || m_valid) && n < 1000) begin
         step();
         n++;
      end
      chk("drain", 64'(exp_q.size() == 0 && !m_valid), 64'd1);
   endtask

   bit done;

   initial begin
      rst = 1'b1; fft_valid = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
      fft_re = '0; fft_im = '0;
      step(); step();
      rst = 1'b0;
      mon_en = 1'b1;
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);

      // single ramp frame
      m_ready = 1'b1;
      send_frame(1'b1, 0);
      drain();
      chk("t1_frames", 64'(frame_cnt), 64'd1);
      chk("t1_ovf", 64'(overflow), 64'd0);

      // three back-to-back frames
      do_reset();
      m_ready = 1'b1;
      repeat (3) send_frame(1'b0, 0);
      drain();
      chk("t2_frames", 64'(frame_cnt), 64'd3);
      chk("t2_drops", 64'(drop_cnt), 64'd0);

      // stalled sink: third frame is dropped
      do_reset();
      m_ready = 1'b0;
      repeat (3) send_frame(1'b0, 0);
      chk("t3_drops", 64'(drop_cnt), 64'd1);
      chk("t3_ovf", 64'(overflow), 64'd1);
      drain();
      chk("t3_frames", 64'(frame_cnt), 64'd2);
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0; step();
      chk("t3_ovf_clr", 64'(overflow), 64'd0);
      chk("t3_drops_kept", 64'(drop_cnt), 64'd1);

      // random ready and input gaps
      do_reset();
      done = 1'b0;
      fork
         begin
            repeat (6) send_frame(1'b0, 4);
            done = 1'b1;
         end
         begin
            while (!done) begin
               m_ready = 1'($urandom_range(0, 1));
               step();
            end
         end
      join
      drain();

      // last-beat release coincides with next frame's bin 0
      do_reset();
      m_ready = 1'b0;
      repeat (2) send_frame(1'b0, 0);
      m_ready = 1'b1;
      for (int n = 0; n < 200 && !(m_valid && m_last); n++) step();
      chk("t5_last_seen", 64'(m_valid && m_last), 64'd1);
      send_frame(1'b0, 0);
      drain();
      chk("t5_drops", 64'(drop_cnt), 64'd0);
      chk("t5_frames", 64'(frame_cnt), 64'd3);

      // reset mid-frame while streaming
      do_reset();
      m_ready = 1'b1;
      send_frame(1'b1, 0);
      for (int i = 0; i < 30; i++) begin
         fft_valid = 1'b1; fft_re = DW'($urandom); fft_im = DW'($urandom);
         step();
      end
      chk("t6_streaming", 64'(m_valid), 64'd1);
      rst = 1'b1; fft_valid = 1'b1;
      step();
      rst = 1'b0; fft_valid = 1'b0;
      chk("t6_rst_valid", 64'(m_valid), 64'd0);
      chk("t6_rst_frames", 64'(frame_cnt), 64'd0);
      chk("t6_rst_drops", 64'(drop_cnt), 64'd0);
      repeat (3) step();
      chk("t6_idle_valid", 64'(m_valid), 64'd0);
      send_frame(1'b1, 0);
      drain();
      chk("t6_frames", 64'(frame_cnt), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
